// File: rtl/comp_serial_seq.sv
// Purpose: bit-serial MSB-first magnitude comparator; one compare slice walks captured operands, stops at first differing bit.
// Latency: start accept to done is WIDTH-p cycles (p = first differing bit from bit 0), WIDTH cycles when equal.
// Backpressure: none; start is only sampled in IDLE, requests arriving while busy are dropped, not queued.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   start             compare request, accepted only in IDLE
//   a, b              WIDTH-bit unsigned operands, captured on the accepting edge
//   busy              high in SCAN and DONE
//   done              one-cycle pulse while in DONE
//   l, g, e           one-hot result (A<B, A>B, A==B), held until the next accepted start
module comp_serial_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             l,
    output logic             g,
    output logic             e
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] ra_q, ra_d;
    logic [WIDTH-1:0] rb_q, rb_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             l_q, l_d;
    logic             g_q, g_d;
    logic             e_q, e_d;

    // Operands and index are widened to fixed sizes so the bit select stays
    // well-formed for every legal WIDTH, including WIDTH=1.
    logic [31:0] ra_ext;
    logic [31:0] rb_ext;
    logic [4:0]  idx_ext;
    logic        bit_a;
    logic        bit_b;
    logic        lt;
    logic        gt;

    assign ra_ext  = 32'(ra_q);
    assign rb_ext  = 32'(rb_q);
    assign idx_ext = 5'(idx_q);
    assign bit_a   = ra_ext[idx_ext];
    assign bit_b   = rb_ext[idx_ext];

    // The single 1-bit compare slice.
    assign lt = ~bit_a & bit_b;
    assign gt = bit_a & ~bit_b;

    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        idx_d   = idx_q;
        l_d     = l_q;
        g_d     = g_q;
        e_d     = e_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    ra_d    = a;
                    rb_d    = b;
                    idx_d   = IW'(WIDTH - 1);
                    l_d     = 1'b0;
                    g_d     = 1'b0;
                    e_d     = 1'b0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (lt) begin
                    l_d     = 1'b1;
                    state_d = DONE;
                end else if (gt) begin
                    g_d     = 1'b1;
                    state_d = DONE;
                end else if (idx_q == '0) begin
                    e_d     = 1'b1;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - IW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            idx_q   <= '0;
            l_q     <= 1'b0;
            g_q     <= 1'b0;
            e_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            idx_q   <= idx_d;
            l_q     <= l_d;
            g_q     <= g_d;
            e_q     <= e_d;
        end
    end

    // Outputs decode straight from registers; no input reaches them combinationally.
    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign l    = l_q;
    assign g    = g_q;
    assign e    = e_q;

endmodule

// File: tb/tb_comp_serial_seq.sv
module tb_comp_serial_seq;

    logic       clk;
    logic       rst;

    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy, done, l, g, e;

    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       busy1, done1, l1, g1, e1;

    int checks;
    int errors;

    comp_serial_seq #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .l     (l),
        .g     (g),
        .e     (e)
    );

    comp_serial_seq #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .busy  (busy1),
        .done  (done1),
        .l     (l1),
        .g     (g1),
        .e     (e1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected done latency: WIDTH-p for first differing bit p, WIDTH if equal.
    function automatic int exp_k(input logic [7:0] av, input logic [7:0] bv);
        for (int p = 7; p >= 0; p--) begin
            if (av[p] != bv[p]) return 8 - p;
        end
        return 8;
    endfunction

    function automatic logic [2:0] exp_lge(input logic [7:0] av, input logic [7:0] bv);
        if (av < bv) return 3'b100;
        if (av > bv) return 3'b010;
        return 3'b001;
    endfunction

    // Pulse start for one edge and wait (bounded) for done; reports latency,
    // result, and busy/done one edge after done.
    task automatic run_cmp8(input logic [7:0] av, input logic [7:0] bv,
                            output int lat, output logic [2:0] lge,
                            output logic busy_after, output logic done_after);
        a = av;
        b = bv;
        start = 1'b1;
        step();
        start = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        lat = -1;
        lge = 3'b000;
        for (int i = 1; i <= 20 && lat < 0; i++) begin
            step();
            if (done) begin
                lat = i;
                lge = {l, g, e};
            end
        end
        step();
        busy_after = busy;
        done_after = done;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0; a = '0; b = '0;
        start1 = 1'b0; a1 = '0; b1 = '0;
        #12;
        checks++;
        if ({busy, done, l, g, e} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_w8: got %b want 00000", {busy, done, l, g, e});
        end
        checks++;
        if ({busy1, done1, l1, g1, e1} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_w1: got %b want 00000", {busy1, done1, l1, g1, e1});
        end
        rst = 1'b0;
        step();
        checks++;
        if ({busy, done, l, g, e} !== 5'b00000) begin
            errors++;
            $display("FAIL idle_after_reset: got %b want 00000", {busy, done, l, g, e});
        end
    endtask

    task automatic test_equal();
        a = 8'hA5; b = 8'hA5; start = 1'b1;
        step();                              // edge 0
        start = 1'b0;
        checks++;
        if ({busy, done, l, g, e} !== 5'b10000) begin
            errors++;
            $display("FAIL eq_accept: got %b want 10000", {busy, done, l, g, e});
        end
        for (int i = 1; i <= 9; i++) begin
            step();
            checks++;
            if (done !== (i == 8) || busy !== (i <= 8)) begin
                errors++;
                $display("FAIL eq_edge%0d: done=%b busy=%b want done=%b busy=%b",
                         i, done, busy, (i == 8), (i <= 8));
            end
            if (i == 8) begin
                checks++;
                if ({l, g, e} !== 3'b001) begin
                    errors++;
                    $display("FAIL eq_result: got %b want 001", {l, g, e});
                end
            end
        end
        checks++;
        if ({l, g, e} !== 3'b001) begin
            errors++;
            $display("FAIL eq_hold: got %b want 001", {l, g, e});
        end
    endtask

    task automatic test_msb_diff();
        int lat;
        logic [2:0] lge;
        logic ba, da;
        run_cmp8(8'h80, 8'h7F, lat, lge, ba, da);
        checks++;
        if (lat != 1 || lge !== 3'b010) begin
            errors++;
            $display("FAIL msb_gt: lat=%0d lge=%b want lat=1 lge=010", lat, lge);
        end
        checks++;
        if (ba !== 1'b0 || da !== 1'b0) begin
            errors++;
            $display("FAIL msb_gt_end: busy=%b done=%b want 0 0", ba, da);
        end
        // New accept must clear the previous g.
        a = 8'h12; b = 8'h13; start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if ({l, g, e} !== 3'b000) begin
            errors++;
            $display("FAIL clear_on_accept: got %b want 000", {l, g, e});
        end
        lat = -1;
        for (int i = 1; i <= 20 && lat < 0; i++) begin
            step();
            if (done) begin
                lat = i;
                lge = {l, g, e};
            end
        end
        checks++;
        if (lat != 8 || lge !== 3'b100) begin
            errors++;
            $display("FAIL lsb_lt: lat=%0d lge=%b want lat=8 lge=100", lat, lge);
        end
        step();
        step();
    endtask

    task automatic test_start_while_busy();
        a = 8'h01; b = 8'h00; start = 1'b1;
        step();                              // edge 0
        start = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            step();
            checks++;
            if (done !== (i == 8 || i == 11) || busy !== (i != 9 && i != 12)) begin
                errors++;
                $display("FAIL busy_edge%0d: done=%b busy=%b want done=%b busy=%b",
                         i, done, busy, (i == 8 || i == 11), (i != 9 && i != 12));
            end
            if (i == 8 || i == 10 || i == 11) begin
                checks++;
                if ({l, g, e} !== ((i == 10) ? 3'b000 : 3'b010)) begin
                    errors++;
                    $display("FAIL busy_result_edge%0d: got %b want %b",
                             i, {l, g, e}, ((i == 10) ? 3'b000 : 3'b010));
                end
            end
            if (i == 2) begin
                start = 1'b1;
                a = 8'hFF;
            end
            if (i == 10) start = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [2:0] lge;
        logic ba, da;
        a = 8'h05; b = 8'h03; start = 1'b1;
        step();                              // edge 0
        start = 1'b0;
        step(); step(); step();              // idx now 4
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, l, g, e} !== 5'b00000) begin
            errors++;
            $display("FAIL rst_mid_async: got %b want 00000", {busy, done, l, g, e});
        end
        step(); step();
        #2;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL rst_mid_no_done%0d: done=%b busy=%b want 0 0", i, done, busy);
            end
        end
        run_cmp8(8'h00, 8'h01, lat, lge, ba, da);
        checks++;
        if (lat != 8 || lge !== 3'b100) begin
            errors++;
            $display("FAIL rst_mid_after: lat=%0d lge=%b want lat=8 lge=100", lat, lge);
        end
    endtask

    task automatic test_back_to_back_w1();
        a1 = 1'b1; b1 = 1'b0; start1 = 1'b1;
        step();                              // edge 0
        for (int i = 1; i <= 12; i++) begin
            step();
            checks++;
            if (done1 !== (i % 3 == 1) || g1 !== ((i % 3) != 0)) begin
                errors++;
                $display("FAIL w1_b2b_edge%0d: done=%b g=%b want done=%b g=%b",
                         i, done1, g1, (i % 3 == 1), ((i % 3) != 0));
            end
        end
        start1 = 1'b0;
        step(); step();
        a1 = 1'b1; b1 = 1'b1; start1 = 1'b1;
        step();
        start1 = 1'b0;
        step();
        checks++;
        if ({done1, l1, g1, e1} !== 4'b1001) begin
            errors++;
            $display("FAIL w1_equal: got %b want 1001", {done1, l1, g1, e1});
        end
        step();
        a1 = 1'b0; b1 = 1'b1; start1 = 1'b1;
        step();
        start1 = 1'b0;
        step();
        checks++;
        if ({done1, l1, g1, e1} !== 4'b1100) begin
            errors++;
            $display("FAIL w1_less: got %b want 1100", {done1, l1, g1, e1});
        end
        step();
    endtask

    task automatic test_random();
        int lat;
        logic [2:0] lge;
        logic ba, da;
        logic [7:0] av, bv;
        for (int n = 0; n < 1000; n++) begin
            av = 8'($urandom);
            bv = (n % 4 == 0) ? av : ((n % 4 == 1) ? (av ^ 8'(1 << $urandom_range(0, 7))) : 8'($urandom));
            run_cmp8(av, bv, lat, lge, ba, da);
            checks++;
            if (lat != exp_k(av, bv) || lge !== exp_lge(av, bv) || ba !== 1'b0 || da !== 1'b0) begin
                errors++;
                $display("FAIL rand%0d a=%h b=%h: lat=%0d lge=%b end=%b%b want lat=%0d lge=%b end=00",
                         n, av, bv, lat, lge, ba, da, exp_k(av, bv), exp_lge(av, bv));
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_equal();
        test_msb_diff();
        test_start_while_busy();
        test_reset_mid();
        test_back_to_back_w1();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
